if_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter, selects the next PC (sequential, branch/jump redirect, exception vector), and runs a request/acknowledge handshake with a variable-latency instruction memory. It presents a fetched instruction and its PC+4 to IF/ID with a valid flag, and honours hazard-unit stalls.

---
 rtl/if_fetch_unit.sv | 110 +++++++++++
 tb/tb_if_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with a variable-latency
// instruction memory and presents one instruction at a time to IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  input  logic        exception,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4,
  output logic [31:0] instruction,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    READY   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        evt;
  logic [31:0] evt_pc;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

  function automatic logic [31:0] next_seq(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  assign evt    = exception | redirect_en;
  assign evt_pc = exception ? EXC_VECTOR : align_word(redirect_target);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= 32'h0;
      instr_valid <= 1'b0;
      instruction <= 32'h0;
      pc_out      <= 32'h0;
      pc_plus_4   <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (!imem_req) begin
            // No request outstanding: a redirect just moves the PC; otherwise issue.
            if (evt) begin
              pc <= evt_pc;
            end else begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end else if (imem_ack) begin
            imem_req <= 1'b0;
            if (evt) begin
              pc          <= evt_pc;
              instr_valid <= 1'b0;
            end else begin
              instruction <= imem_rdata;
              pc_out      <= pc;
              pc_plus_4   <= next_seq(pc);
              instr_valid <= 1'b1;
              state       <= READY;
            end
          end else if (evt) begin
            pc    <= evt_pc;
            state <= DISCARD;
          end
        end
        READY: begin
          if (evt) begin
            pc          <= evt_pc;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end else if (!stall) begin
            pc          <= next_seq(pc);
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        DISCARD: begin
          // Stale request keeps its address until the memory answers; the data is dropped.
          if (evt) pc <= evt_pc;
          if (imem_ack) begin
            imem_addr <= evt ? evt_pc : pc;
            state     <= FETCH;
          end
        end
        default: begin
          state    <= FETCH;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, 1- and 3-cycle memory, stall,
// redirect/exception interactions, PC wrap and reset during a request.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_target;
  logic        exception;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4;
  logic [31:0] instruction;
  logic        instr_valid;

  int errors = 0;
  int checks = 0;

  if_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .exception       (exception),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .pc_plus_4       (pc_plus_4),
    .instruction     (instruction),
    .instr_valid     (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_target = 32'h0;
    exception = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    step(); step();
    check("rst_req",   {31'h0, imem_req}, 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pcout", pc_out, 32'h0);
    check("rst_pc4",   pc_plus_4, 32'h0);

    // First fetch with a one-cycle memory
    reset = 1'b0;
    step();
    check("f1_req",  {31'h0, imem_req}, 32'h1);
    check("f1_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    check("f1_valid", {31'h0, instr_valid}, 32'h1);
    check("f1_instr", instruction, 32'h2008_0005);
    check("f1_pc4",   pc_plus_4, 32'h4);
    check("f1_pcout", pc_out, 32'h0);
    check("f1_req0",  {31'h0, imem_req}, 32'h0);

    // Stall held in READY
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("st_valid", {31'h0, instr_valid}, 32'h1);
      check("st_instr", instruction, 32'h2008_0005);
      check("st_pc4",   pc_plus_4, 32'h4);
      check("st_req",   {31'h0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    step();
    check("cons_valid", {31'h0, instr_valid}, 32'h0);
    check("cons_req",   {31'h0, imem_req}, 32'h0);
    step();
    check("f2_req",  {31'h0, imem_req}, 32'h1);
    check("f2_addr", imem_addr, 32'h4);

    // Three-cycle memory, redirect arrives while the request is pending
    redirect_en = 1'b1; redirect_target = 32'h0000_0043;
    step();
    redirect_en = 1'b0; redirect_target = 32'h0;
    check("dis_req",   {31'h0, imem_req}, 32'h1);
    check("dis_addr",  imem_addr, 32'h4);
    check("dis_valid", {31'h0, instr_valid}, 32'h0);
    step();
    check("dis_req2",  {31'h0, imem_req}, 32'h1);
    check("dis_addr2", imem_addr, 32'h4);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    check("dis_drop",  {31'h0, instr_valid}, 32'h0);
    check("rd_req",    {31'h0, imem_req}, 32'h1);
    check("rd_addr",   imem_addr, 32'h40);
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    check("rd_valid", {31'h0, instr_valid}, 32'h1);
    check("rd_instr", instruction, 32'h1111_2222);
    check("rd_pcout", pc_out, 32'h40);
    check("rd_pc4",   pc_plus_4, 32'h44);

    // Exception beats redirect while READY (stall must not block it)
    stall = 1'b1; exception = 1'b1; redirect_en = 1'b1; redirect_target = 32'h200;
    step();
    stall = 1'b0; exception = 1'b0; redirect_en = 1'b0; redirect_target = 32'h0;
    check("exc_valid", {31'h0, instr_valid}, 32'h0);
    check("exc_req0",  {31'h0, imem_req}, 32'h0);
    step();
    check("exc_req",  {31'h0, imem_req}, 32'h1);
    check("exc_addr", imem_addr, 32'h8000_0180);

    // Ack coincident with redirect drops the data
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    redirect_en = 1'b1; redirect_target = 32'h100;
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0; redirect_en = 1'b0; redirect_target = 32'h0;
    check("co_valid", {31'h0, instr_valid}, 32'h0);
    check("co_req0",  {31'h0, imem_req}, 32'h0);
    step();
    check("co_req",  {31'h0, imem_req}, 32'h1);
    check("co_addr", imem_addr, 32'h100);

    // PC wrap at the top of the address space
    redirect_en = 1'b1; redirect_target = 32'hFFFF_FFFF;
    step();
    redirect_en = 1'b0; redirect_target = 32'h0;
    imem_ack = 1'b1;
    step();
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    check("wr_req",  {31'h0, imem_req}, 32'h1);
    imem_rdata = 32'h0000_ABCD;
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    check("wr_valid", {31'h0, instr_valid}, 32'h1);
    check("wr_pcout", pc_out, 32'hFFFF_FFFC);
    check("wr_pc4",   pc_plus_4, 32'h0);
    check("wr_instr", instruction, 32'h0000_ABCD);
    step();
    step();
    check("wr_nreq",  {31'h0, imem_req}, 32'h1);
    check("wr_naddr", imem_addr, 32'h0);

    // Reset while a request is outstanding; a stale ack must be ignored
    reset = 1'b1;
    step();
    check("mr_req", {31'h0, imem_req}, 32'h0);
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    check("mr_valid", {31'h0, instr_valid}, 32'h0);
    check("mr_req1",  {31'h0, imem_req}, 32'h1);
    check("mr_addr",  imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
